dual_switch_debouncer: RTL and testbench
========================================

# dual_switch_debouncer

Two-channel switch conditioner that sits directly upstream of the two-input AND gate. It synchronises raw, asynchronous switch inputs into the `clk` domain and debounces them. Each channel drives one gate input (`a`, `b`) with a clean, glitch-free level, plus single-cycle edge pulses for downstream event logic. Both channels are identical and fully independent.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised cycles a new level must hold before the output accepts it. Legal range is 2 to 2^20. Production builds use large values; simulation uses 4.
- `clk`  input  1  single system clock. All state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `sw_a`  input  1  raw switch A; asynchronous and may bounce.
- `sw_b`  input  1  raw switch B; asynchronous and may bounce.
- `a`  output  1  debounced level of `sw_a`; feeds AND gate input `a`.
- `b`  output  1  debounced level of `sw_b`; feeds AND gate input `b`.
- `a_rise`, `a_fall`  output  1 each  one-cycle pulse when `a` goes 0→1 or 1→0.
- `b_rise`, `b_fall`  output  1 each  one-cycle pulse when `b` goes 0→1 or 1→0.
- `changed`  output  1  OR of all four edge pulses.

## Operation
- **Per channel state:** two-flop synchroniser `s1` → `s2`, a stability counter `cnt` of width `$clog2(STABLE_CYCLES)`, and the registered output level.
- **Reset:** asserting `rst_n` low clears `s1`, `s2`, `cnt`, the levels `a` and `b`, and all pulse outputs to 0 immediately, without waiting for a clock edge. Reset may hit mid-count; the partial count is discarded. After release, the inputs are re-evaluated from zero.
- **Two-state machine per channel:** the states are STABLE (`s2 == level`) and PENDING (`s2 != level`). The counter runs only in PENDING.
- **STABLE:** on every edge, `cnt <= 0`.
- **PENDING, not yet qualified:** if `cnt != STABLE_CYCLES-1`, then `cnt <= cnt+1`.
- **PENDING, qualified:** if `cnt == STABLE_CYCLES-1`, then on that edge:
  - `level <= s2`;
  - `cnt <= 0`;
  - the matching rise or fall pulse is 1 for the next cycle.
- **Bounce rejection:** any return of `s2` to the current level during PENDING zeroes `cnt` on that edge. A glitch shorter than `STABLE_CYCLES` synchronised cycles never reaches the output.
- **Pulse outputs:** registered. Each is high for exactly one cycle, coincident with the first cycle in which the new level is visible. Rise and fall can never both be high on the same channel.
- **Counter width:** `cnt` never exceeds `STABLE_CYCLES-1`, so it never wraps.
- **Simultaneous events:** both channels qualifying on the same edge is legal. Both pulses assert together and `changed` is 1 for one cycle.

## Timing
- **Latency:** a raw change sampled by `s1` at edge E first appears in `s2` after edge E+1. If it is held, `a`/`b` change on edge E+1+STABLE_CYCLES. With `STABLE_CYCLES=4`, that is 5 edges after E, i.e. 6 sampling edges counted from E.
- **Minimum accepted pulse:** the raw level must be held for at least `STABLE_CYCLES` clock periods plus synchroniser uncertainty (up to 1 cycle) to be accepted.
- **Throughput:** after a change is accepted, the next opposite change needs a fresh full `STABLE_CYCLES` qualification. Outputs can toggle at most once every `STABLE_CYCLES` cycles.
- **Glitch-free outputs:** all outputs are driven directly from flops, with no combinational path from `sw_*` to any output.

## Test plan
All scenarios use `STABLE_CYCLES=4` and a 10 ns clock.
- **Reset:** hold `rst_n`=0 with `sw_a`=`sw_b`=1 → `a`=`b`=0 and all pulses 0. Release reset → `a` and `b` rise 5 edges after the first sampling edge, with `a_rise` and `b_rise` each high for exactly 1 cycle and `changed`=1 for that cycle.
- **Bounce rejection:** `sw_a` toggles 0/1 every 20 ns for 100 ns, then holds 1 → `a` stays 0 through the bounce and rises exactly once, 4 cycles after `s2` settles. Exactly one `a_rise`, no `a_fall`.
- **Short glitch:** a 30 ns high pulse on `sw_b` (3 cycles) → `b` stays 0 and no pulse asserts. A 40 ns pulse aligned to the clock → `b` rises, then falls again after a further 4 stable cycles.
- **Simultaneous qualification:** `sw_a` and `sw_b` both go 0→1 on the same edge → `a_rise` and `b_rise` assert on the same cycle and `changed` is high for 1 cycle. Following the gate truth table, a downstream `out` would then be 1.
- **Reset mid-count:** `sw_a`=1, then assert `rst_n`=0 asynchronously two cycles into PENDING → `a`=0 and pulses clear immediately. After release, a full 5-edge qualification is required again.
- **Fall path:** with `a`=1, drop `sw_a` to 0 and hold → `a_fall` pulses once, `a`=0, and `a_rise` stays 0.

Source files
------------

// File: rtl/dual_switch_debouncer.sv
// Two independent switch channels. Each one synchronises its raw input, debounces it
// with a stability counter and produces a clean level plus registered edge pulses.
module dsd_lane #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic edge_nxt
);
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} state_e;

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, rise_nxt, fall_nxt;
  state_e        state;

  // The state is implied by comparing the synchronised input with the held level.
  assign state    = (s2 == level) ? STABLE : PENDING;
  assign edge_nxt = rise_nxt | fall_nxt;

  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE:  cnt_nxt = '0;
      PENDING: begin
        if (cnt == CNT_MAX) begin
          level_nxt = s2;
          cnt_nxt   = '0;
          rise_nxt  = s2;
          fall_nxt  = ~s2;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= sw;
      s2    <= s1;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end
endmodule

module dual_switch_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic changed
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] sw, level, rise, fall, edge_nxt;

  assign sw = {sw_b, sw_a};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dsd_lane #(.STABLE_CYCLES(STABLE_CYCLES)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw[i]),
        .level    (level[i]),
        .rise     (rise[i]),
        .fall     (fall[i]),
        .edge_nxt (edge_nxt[i])
      );
    end
  endgenerate

  // Registered from the lanes' next-pulse terms so it aligns with the pulses themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |edge_nxt;
  end

  assign a      = level[0];
  assign b      = level[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];
endmodule

// File: tb/tb_dual_switch_debouncer.sv
// Bench for dual_switch_debouncer: a window-based reference model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_dual_switch_debouncer;
  localparam int SC = 4;

  logic clk, rst_n, sw_a, sw_b;
  logic a, b, a_rise, a_fall, b_rise, b_fall, changed;

  int total = 0;
  int bad   = 0;

  dual_switch_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b),
    .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .changed(changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a level flips once the last SC synchronised samples all disagree with it.
  logic [1:0]    ms1, ms2, mlev, mrise, mfall;
  logic          mchg;
  logic [SC-1:0] win [2];
  int            nv  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms1 = '0; ms2 = '0; mlev = '0; mrise = '0; mfall = '0; mchg = 1'b0;
      for (int c = 0; c < 2; c++) begin
        win[c] = '0;
        nv[c]  = 0;
      end
    end else begin
      mrise = '0;
      mfall = '0;
      for (int c = 0; c < 2; c++) begin
        win[c] = {win[c][SC-2:0], ms2[c]};
        if (nv[c] < SC) nv[c]++;
        if (nv[c] == SC && win[c] == {SC{~mlev[c]}}) begin
          mlev[c]  = ~mlev[c];
          mrise[c] = mlev[c];
          mfall[c] = ~mlev[c];
        end
      end
      mchg = |{mrise, mfall};
      ms2  = ms1;
      ms1  = {sw_b, sw_a};
    end
  end

  always @(negedge clk) begin
    chk("a",       a,       mlev[0]);
    chk("b",       b,       mlev[1]);
    chk("a_rise",  a_rise,  mrise[0]);
    chk("a_fall",  a_fall,  mfall[0]);
    chk("b_rise",  b_rise,  mrise[1]);
    chk("b_fall",  b_fall,  mfall[1]);
    chk("changed", changed, mchg);
  end

  int nar, naf, nbr, nbf, nchg, nboth;

  task automatic clr();
    nar = 0; naf = 0; nbr = 0; nbf = 0; nchg = 0; nboth = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      nar   += int'(a_rise);
      naf   += int'(a_fall);
      nbr   += int'(b_rise);
      nbf   += int'(b_fall);
      nchg  += int'(changed);
      nboth += int'(a_rise & b_rise);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw_a  = 1'b0;
    sw_b  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(2);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_a  = 1'b1;
    sw_b  = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_a", a, 1'b0);
    chk("rst_b", b, 1'b0);
    chk("rst_pulses", a_rise | a_fall | b_rise | b_fall, 1'b0);
    chk("rst_changed", changed, 1'b0);

    // Release: first sampling edge is the next posedge; levels move on its 6th edge.
    rst_n = 1'b1;
    run(5);
    chk("rel_a_early", a, 1'b0);
    chk("rel_b_early", b, 1'b0);
    run(1);
    chk("rel_a", a, 1'b1);
    chk("rel_b", b, 1'b1);
    chk("rel_a_rise", a_rise, 1'b1);
    chk("rel_b_rise", b_rise, 1'b1);
    chk("rel_changed", changed, 1'b1);
    run(1);
    chk("rel_a_rise_end", a_rise, 1'b0);
    chk("rel_changed_end", changed, 1'b0);

    // Bounce on sw_a: 2-cycle segments 1,0,1,0 then hold 1.
    do_reset();
    clr();
    for (int i = 0; i < 5; i++) begin
      sw_a = (i % 2 == 0);
      run(2);
    end
    chk("bnc_a_held", a, 1'b0);
    run(10);
    chk("bnc_a", a, 1'b1);
    chk_int("bnc_rises", nar, 1);
    chk_int("bnc_falls", naf, 0);

    // Short glitch on sw_b, then an exactly-qualifying 4-cycle pulse.
    do_reset();
    clr();
    sw_b = 1'b1;
    run(3);
    sw_b = 1'b0;
    run(10);
    chk("gl_b", b, 1'b0);
    chk_int("gl_rises", nbr, 0);
    chk_int("gl_falls", nbf, 0);
    clr();
    sw_b = 1'b1;
    run(4);
    sw_b = 1'b0;
    run(12);
    chk_int("p4_rises", nbr, 1);
    chk_int("p4_falls", nbf, 1);
    chk("p4_b", b, 1'b0);

    // Simultaneous qualification.
    do_reset();
    clr();
    sw_a = 1'b1;
    sw_b = 1'b1;
    run(8);
    chk_int("sim_both", nboth, 1);
    chk_int("sim_changed", nchg, 1);
    chk("sim_and", a & b, 1'b1);

    // Reset two cycles into PENDING discards the partial count.
    do_reset();
    sw_a = 1'b1;
    run(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_a", a, 1'b0);
    chk("mid_changed", changed, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(5);
    chk("mid_a_early", a, 1'b0);
    run(1);
    chk("mid_a_rise", a_rise, 1'b1);
    // Reset while a pulse is high clears it immediately.
    #2 rst_n = 1'b0;
    #1 chk("pr_a_rise", a_rise, 1'b0);
    chk("pr_a", a, 1'b0);
    chk("pr_changed", changed, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8);
    chk("fall_pre_a", a, 1'b1);

    // Fall path.
    clr();
    sw_a = 1'b0;
    run(10);
    chk_int("fall_falls", naf, 1);
    chk_int("fall_rises", nar, 0);
    chk("fall_a", a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
